// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - loads operand A, operand B and an opcode one load press at a time, then offers them to the ALU stage
module alu_operand_loader #(
    parameter int DW  = 4,
    parameter int OPW = 3
) (
    input  logic           CLOCK_50,
    input  logic           RESET,
    input  logic [DW-1:0]  data_in,
    input  logic           load,
    input  logic           clear,
    input  logic           ready,
    output logic [DW-1:0]  a_out,
    output logic [DW-1:0]  b_out,
    output logic [OPW-1:0] op_out,
    output logic           valid,
    output logic [1:0]     state_out,
    output logic [7:0]     xfer_count
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        ISSUE   = 2'b11
    } state_t;

    state_t         state, state_nx;
    logic [DW-1:0]  a_nx, b_nx;
    logic [OPW-1:0] op_nx;
    logic [7:0]     count_nx;
    logic           s1, s2, s3;
    logic           load_edge;

    // load comes from a key: two flops resynchronise it, the third detects the rise
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= load;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign load_edge = s2 & ~s3;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= LOAD_A;
            a_out      <= '0;
            b_out      <= '0;
            op_out     <= '0;
            xfer_count <= '0;
        end else begin
            state      <= state_nx;
            a_out      <= a_nx;
            b_out      <= b_nx;
            op_out     <= op_nx;
            xfer_count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a_out;
        b_nx     = b_out;
        op_nx    = op_out;
        count_nx = xfer_count;
        if (clear) begin
            state_nx = LOAD_A;
            a_nx     = '0;
            b_nx     = '0;
            op_nx    = '0;
        end else begin
            case (state)
                LOAD_A: if (load_edge) begin
                    a_nx     = data_in;
                    state_nx = LOAD_B;
                end
                LOAD_B: if (load_edge) begin
                    b_nx     = data_in;
                    state_nx = LOAD_OP;
                end
                LOAD_OP: if (load_edge) begin
                    op_nx    = data_in[OPW-1:0];
                    state_nx = ISSUE;
                end
                ISSUE: if (ready) begin
                    count_nx = xfer_count + 8'd1;
                    state_nx = LOAD_A;
                end
                default: state_nx = LOAD_A;
            endcase
        end
    end

    assign valid     = (state == ISSUE);
    assign state_out = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - scoreboard bench for alu_operand_loader
module tb_alu_operand_loader;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic [3:0] data_in;
    logic       load, clear, ready;
    logic [3:0] a_out, b_out;
    logic [2:0] op_out;
    logic       valid;
    logic [1:0] state_out;
    logic [7:0] xfer_count;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } op_t;

    op_t        sb[$];
    logic [7:0] exp_count;
    int         errors = 0;
    int         checks = 0;

    alu_operand_loader #(.DW(4), .OPW(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .data_in   (data_in),
        .load      (load),
        .clear     (clear),
        .ready     (ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .op_out    (op_out),
        .valid     (valid),
        .state_out (state_out),
        .xfer_count(xfer_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic load_field(input logic [3:0] d);
        @(negedge CLOCK_50);
        data_in = d;
        load    = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        load = 1'b0;
        repeat (3) @(negedge CLOCK_50);
    endtask

    task automatic load_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        op_t e;
        load_field(a);
        load_field(b);
        load_field(op);
        e.a  = a;
        e.b  = b;
        e.op = op[2:0];
        sb.push_back(e);
        checks++;
        if (valid !== 1'b1 || state_out !== 2'b11) begin
            errors++;
            $display("FAIL load_op_issue: valid=%b state=%b, required valid=1 state=11", valid, state_out);
        end
    endtask

    task automatic handoff();
        op_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL handoff_queue: scoreboard empty, required an expected entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (valid !== 1'b1 || a_out !== e.a || b_out !== e.b || op_out !== e.op) begin
            errors++;
            $display("FAIL handoff_fields: valid=%b a=%h b=%h op=%h, required valid=1 a=%h b=%h op=%h",
                     valid, a_out, b_out, op_out, e.a, e.b, e.op);
        end
        ready = 1'b1;
        @(negedge CLOCK_50);
        ready = 1'b0;
        exp_count = exp_count + 8'd1;
        checks++;
        if (xfer_count !== exp_count || state_out !== 2'b00 || valid !== 1'b0) begin
            errors++;
            $display("FAIL handoff_done: count=%0d state=%b valid=%b, required count=%0d state=00 valid=0",
                     xfer_count, state_out, valid, exp_count);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; data_in = 4'h0; load = 1'b0; clear = 1'b0; ready = 1'b0;
        exp_count = 8'd0;
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if (a_out !== 4'h0 || b_out !== 4'h0 || op_out !== 3'h0 || valid !== 1'b0 ||
            state_out !== 2'b00 || xfer_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: a=%h b=%h op=%h valid=%b state=%b count=%0d, required all zero",
                     a_out, b_out, op_out, valid, state_out, xfer_count);
        end
        RESET = 1'b0;
    endtask

    task automatic test_basic();
        load_op(4'h5, 4'h3, 4'h0);
        checks++;
        if (a_out !== 4'h5 || b_out !== 4'h3 || op_out !== 3'h0) begin
            errors++;
            $display("FAIL basic_fields: a=%h b=%h op=%h, required a=5 b=3 op=0", a_out, b_out, op_out);
        end
        handoff();
    endtask

    task automatic test_latency();
        @(negedge CLOCK_50);
        data_in = 4'h9;
        load    = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if (a_out !== 4'h5) begin
            errors++;
            $display("FAIL latency_k: a=%h, required 5", a_out);
        end
        @(negedge CLOCK_50);
        checks++;
        if (a_out !== 4'h5) begin
            errors++;
            $display("FAIL latency_k1: a=%h, required 5", a_out);
        end
        @(negedge CLOCK_50);
        checks++;
        if (a_out !== 4'h9 || state_out !== 2'b01) begin
            errors++;
            $display("FAIL latency_k2: a=%h state=%b, required a=9 state=01", a_out, state_out);
        end
        data_in = 4'h6;
        repeat (17) @(negedge CLOCK_50);
        checks++;
        if (a_out !== 4'h9 || b_out !== 4'h3 || state_out !== 2'b01) begin
            errors++;
            $display("FAIL latency_hold: a=%h b=%h state=%b, required a=9 b=3 state=01", a_out, b_out, state_out);
        end
        load = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        load_field(4'h2);
        load_field(4'hF);
        sb.push_back('{a: 4'h9, b: 4'h2, op: 3'h7});
        handoff();
    endtask

    task automatic test_backpressure();
        load_op(4'hA, 4'h6, 4'h4);
        repeat (4) @(negedge CLOCK_50);
        load_field(4'hF);
        load_field(4'hF);
        checks++;
        if (valid !== 1'b1 || a_out !== 4'hA || b_out !== 4'h6 || op_out !== 3'h4 ||
            state_out !== 2'b11 || xfer_count !== exp_count) begin
            errors++;
            $display("FAIL backpressure_hold: valid=%b a=%h b=%h op=%h state=%b count=%0d, required 1 a b 6 4 11 %0d",
                     valid, a_out, b_out, op_out, state_out, xfer_count, exp_count);
        end
        handoff();
    endtask

    task automatic test_clear_priority();
        op_t dropped;
        load_op(4'h7, 4'h1, 4'h3);
        dropped = sb.pop_front();
        @(negedge CLOCK_50);
        clear = 1'b1;
        ready = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        ready = 1'b0;
        checks++;
        if (state_out !== 2'b00 || a_out !== 4'h0 || b_out !== 4'h0 || op_out !== 3'h0 ||
            xfer_count !== exp_count || dropped.a !== 4'h7) begin
            errors++;
            $display("FAIL clear_priority: state=%b a=%h b=%h op=%h count=%0d, required 00 0 0 0 %0d",
                     state_out, a_out, b_out, op_out, xfer_count, exp_count);
        end
    endtask

    task automatic test_async_reset();
        op_t dropped;
        load_field(4'h4);
        load_field(4'h8);
        @(negedge CLOCK_50);
        #2 RESET = 1'b1;
        #1;
        exp_count = 8'd0;
        checks++;
        if (state_out !== 2'b00 || a_out !== 4'h0 || b_out !== 4'h0 || op_out !== 3'h0 ||
            valid !== 1'b0 || xfer_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: state=%b a=%h b=%h op=%h valid=%b count=%0d, required all zero",
                     state_out, a_out, b_out, op_out, valid, xfer_count);
        end
        data_in = 4'hC;
        load    = 1'b1;
        @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        checks++;
        if (a_out !== 4'hC || state_out !== 2'b01) begin
            errors++;
            $display("FAIL reset_release_load: a=%h state=%b, required a=c state=01", a_out, state_out);
        end
        load = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        load_field(4'h1);
        load_field(4'h2);
        sb.push_back('{a: 4'hC, b: 4'h1, op: 3'h2});
        handoff();
        load_op(4'hE, 4'hD, 4'h5);
        dropped = sb.pop_front();
        @(negedge CLOCK_50);
        ready = 1'b1;
        #2 RESET = 1'b1;
        #1;
        exp_count = 8'd0;
        checks++;
        if (xfer_count !== 8'd0 || state_out !== 2'b00 || valid !== 1'b0 || dropped.b !== 4'hD) begin
            errors++;
            $display("FAIL reset_in_issue: count=%0d state=%b valid=%b, required 0 00 0",
                     xfer_count, state_out, valid);
        end
        @(negedge CLOCK_50);
        ready = 1'b0;
        RESET = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] a, b, o;
        a = 4'h0; b = 4'h0; o = 4'h0;
        for (int i = 0; i < 256; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            o = 4'($urandom_range(0, 15));
            load_op(a, b, o);
            handoff();
        end
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if (xfer_count !== 8'd0 || a_out !== a || b_out !== b || op_out !== o[2:0]) begin
            errors++;
            $display("FAIL wrap: count=%0d a=%h b=%h op=%h, required count=0 a=%h b=%h op=%h",
                     xfer_count, a_out, b_out, op_out, a, b, o[2:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_clear_priority();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
